// File: rtl/regalu_sequencer.sv
// regalu_sequencer: serialises load-immediate and ALU commands onto a register-file + ALU datapath
// Ports:
//   clk, rst_n                    clock, asynchronous active-low reset
//   cmd_valid/cmd_ready           command handshake; cmd_load selects load-immediate over ALU op
//   cmd_opcode, cmd_rd/rs1/rs2    ALU opcode and register addresses
//   cmd_imm                       immediate for load commands
//   rsp_valid/rsp_ready/rsp_data  response handshake carrying the value written to rd
//   busy, op_count                not-idle flag, retired-command counter (wraps)
//   dp_*                          datapath read/write ports, opcode and ALU result
module regalu_sequencer #(
    parameter bit PROTECT_R0 = 1'b1,
    parameter int CNT_W      = 16
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             cmd_valid,
    output logic             cmd_ready,
    input  logic             cmd_load,
    input  logic [1:0]       cmd_opcode,
    input  logic [4:0]       cmd_rd,
    input  logic [4:0]       cmd_rs1,
    input  logic [4:0]       cmd_rs2,
    input  logic [31:0]      cmd_imm,
    output logic             rsp_valid,
    input  logic             rsp_ready,
    output logic [31:0]      rsp_data,
    output logic             busy,
    output logic [CNT_W-1:0] op_count,
    output logic             dp_we3,
    output logic [4:0]       dp_a1,
    output logic [4:0]       dp_a2,
    output logic [4:0]       dp_a3,
    output logic [31:0]      dp_wd3,
    output logic [1:0]       dp_opcode,
    input  logic [31:0]      dp_alu_result
);
    typedef enum logic [1:0] {IDLE, READ, WB, RESP} state_t;
    state_t state, state_nx;
    logic [4:0] rd_q;
    always_ff @(posedge clk or negedge rst_n)
        if (!rst_n) state <= IDLE;
        else        state <= state_nx;
    always_comb begin
        state_nx = (state == IDLE) ? (cmd_valid ? (cmd_load ? WB : READ) : IDLE) :
                   (state == READ) ? WB :
                   (state == WB)   ? RESP :
                   (rsp_ready ? IDLE : RESP);
    end
    // dp_a3 is loaded on entry to WB, so it already names rd while WB is active
    always_comb begin
        cmd_ready = state == IDLE;
        busy      = state != IDLE;
        rsp_valid = state == RESP;
        dp_we3    = (state == WB) && !(PROTECT_R0 && dp_a3 == 5'd0);
    end
    // dp_wd3 doubles as the result register: it is loaded with imm or the ALU result on entry to WB
    always_ff @(posedge clk or negedge rst_n)
        if (!rst_n) begin
            rd_q      <= '0;
            dp_a1     <= '0;
            dp_a2     <= '0;
            dp_a3     <= '0;
            dp_wd3    <= '0;
            dp_opcode <= '0;
            rsp_data  <= '0;
            op_count  <= '0;
        end else begin
            if (state == IDLE && cmd_valid) begin
                rd_q <= cmd_rd;
                if (cmd_load) begin
                    dp_a3  <= cmd_rd;
                    dp_wd3 <= cmd_imm;
                end else begin
                    dp_a1     <= cmd_rs1;
                    dp_a2     <= cmd_rs2;
                    dp_opcode <= cmd_opcode;
                end
            end
            if (state == READ) begin
                dp_a3  <= rd_q;
                dp_wd3 <= dp_alu_result;
            end
            if (state == WB) rsp_data <= dp_wd3;
            if (rsp_valid && rsp_ready) op_count <= op_count + CNT_W'(1);
        end
endmodule

// File: tb/tb_regalu_sequencer.sv
// tb_regalu_sequencer: randomized and directed checks of regalu_sequencer against a command-level model
module tb_regalu_sequencer;
    logic        clk = 1'b0;
    logic        rst_n = 1'b1;
    logic        cmd_valid = 1'b0, cmd_ready, cmd_load = 1'b0;
    logic [1:0]  cmd_opcode = '0;
    logic [4:0]  cmd_rd = '0, cmd_rs1 = '0, cmd_rs2 = '0;
    logic [31:0] cmd_imm = '0;
    logic        rsp_valid, rsp_ready = 1'b0;
    logic [31:0] rsp_data;
    logic        busy;
    logic [15:0] op_count;
    logic        dp_we3;
    logic [4:0]  dp_a1, dp_a2, dp_a3;
    logic [31:0] dp_wd3, dp_alu_result;
    logic [1:0]  dp_opcode;
    int checks = 0, errors = 0, we_cnt = 0;
    logic [31:0] rf [32] = '{default: 32'd0};
    logic [31:0] ref_rf [32] = '{default: 32'd0};
    logic [15:0] ref_cnt = '0;

    regalu_sequencer #(.PROTECT_R0(1'b1), .CNT_W(16)) dut (
        .clk(clk), .rst_n(rst_n), .cmd_valid(cmd_valid), .cmd_ready(cmd_ready),
        .cmd_load(cmd_load), .cmd_opcode(cmd_opcode), .cmd_rd(cmd_rd), .cmd_rs1(cmd_rs1),
        .cmd_rs2(cmd_rs2), .cmd_imm(cmd_imm), .rsp_valid(rsp_valid), .rsp_ready(rsp_ready),
        .rsp_data(rsp_data), .busy(busy), .op_count(op_count), .dp_we3(dp_we3),
        .dp_a1(dp_a1), .dp_a2(dp_a2), .dp_a3(dp_a3), .dp_wd3(dp_wd3),
        .dp_opcode(dp_opcode), .dp_alu_result(dp_alu_result));

    always #5 clk = ~clk;

    function automatic logic [31:0] alu(input logic [1:0] op, input logic [31:0] a, b);
        return op == 2'd0 ? a + b : op == 2'd1 ? a - b : op == 2'd2 ? a & b : a | b;
    endfunction

    // stand-in datapath: combinational reads and ALU, write on the rising edge
    assign dp_alu_result = alu(dp_opcode, rf[dp_a1], rf[dp_a2]);
    always @(posedge clk) if (dp_we3) rf[dp_a3] <= dp_wd3;
    always @(negedge clk) if (dp_we3) we_cnt++;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s obs=%h exp=%h", tag, obs, exp);
        end
    endtask

    task automatic run(input logic ld, input logic [1:0] op, input logic [4:0] rd, rs1, rs2,
                       input logic [31:0] imm);
        logic [31:0] exp;
        int lat;
        exp = ld ? imm : alu(op, ref_rf[rs1], ref_rf[rs2]);
        @(negedge clk);
        chk("cmd_ready_idle", 32'(cmd_ready), 32'd1);
        cmd_valid = 1'b1; cmd_load = ld; cmd_opcode = op;
        cmd_rd = rd; cmd_rs1 = rs1; cmd_rs2 = rs2; cmd_imm = imm;
        @(posedge clk); #1;
        cmd_valid = 1'b0;
        we_cnt = 0;
        lat = 1;
        while (rsp_valid !== 1'b1 && lat < 10) begin
            if (!ld && lat == 1) begin
                chk("read_a1", 32'(dp_a1), 32'(rs1));
                chk("read_a2", 32'(dp_a2), 32'(rs2));
                chk("read_busy_ready", 32'({busy, cmd_ready}), 32'd2);
            end
            if (lat == (ld ? 1 : 2)) begin
                chk("wb_a3", 32'(dp_a3), 32'(rd));
                chk("wb_wd3", dp_wd3, exp);
            end
            @(posedge clk); #1;
            lat++;
        end
        chk("latency", 32'(lat), ld ? 32'd2 : 32'd3);
        chk("rsp_data", rsp_data, exp);
        rsp_ready = 1'b1;
        @(posedge clk); #1;
        rsp_ready = 1'b0;
        if (rd != 5'd0) ref_rf[rd] = exp;
        ref_cnt++;
        chk("we3_pulses", 32'(we_cnt), rd == 5'd0 ? 32'd0 : 32'd1);
        chk("rf_rd", rf[rd], ref_rf[rd]);
        chk("op_count", 32'(op_count), 32'(ref_cnt));
        chk("idle_after_rsp", 32'({busy, rsp_valid}), 32'd0);
    endtask

    initial begin
        logic [31:0] exp;
        #2 rst_n = 1'b0;
        #1;
        chk("rst_outs", 32'({rsp_valid, dp_we3, busy, cmd_ready}), 32'b0001);
        chk("rst_op_count", 32'(op_count), 32'd0);
        chk("rst_rsp_data", rsp_data, 32'd0);
        chk("rst_dp", {dp_a1, dp_a2, dp_a3, dp_opcode, 15'd0}, 32'd0);
        chk("rst_wd3", dp_wd3, 32'd0);
        @(negedge clk) rst_n = 1'b1;
        // loads, then an ADD reading them
        run(1'b1, 2'd0, 5'd1, 5'd0, 5'd0, 32'h0000_0005);
        run(1'b1, 2'd0, 5'd2, 5'd0, 5'd0, 32'h0000_0003);
        run(1'b0, 2'd0, 5'd3, 5'd1, 5'd2, 32'h0);
        chk("r3_is_8", rf[3], 32'h8);
        // protected r0
        run(1'b1, 2'd0, 5'd0, 5'd0, 5'd0, 32'hDEAD_BEEF);
        run(1'b0, 2'd0, 5'd4, 5'd0, 5'd0, 32'h0);
        chk("r0_unchanged", rf[0], 32'h0);
        // response back-pressure with a competing command held on the inputs
        exp = ref_rf[1] + ref_rf[3];
        @(negedge clk);
        cmd_valid = 1'b1; cmd_load = 1'b0; cmd_opcode = 2'd0;
        cmd_rd = 5'd6; cmd_rs1 = 5'd1; cmd_rs2 = 5'd3;
        @(posedge clk); #1;
        cmd_load = 1'b1; cmd_rd = 5'd7; cmd_imm = 32'h1234_5678;
        repeat (2) @(posedge clk);
        #1;
        for (int i = 0; i < 10; i++) begin
            chk("bp_valid_busy_ready", 32'({rsp_valid, busy, cmd_ready}), 32'b110);
            chk("bp_rsp_data", rsp_data, exp);
            @(posedge clk); #1;
        end
        cmd_valid = 1'b0;
        rsp_ready = 1'b1;
        @(posedge clk); #1;
        rsp_ready = 1'b0;
        ref_rf[6] = exp;
        ref_cnt++;
        chk("bp_op_count", 32'(op_count), 32'(ref_cnt));
        @(posedge clk); #1;
        chk("bp_not_accepted", 32'(busy), 32'd0);
        chk("bp_r7_untouched", rf[7], ref_rf[7]);
        chk("bp_r6", rf[6], ref_rf[6]);
        // randomized commands
        for (int n = 0; n < 40; n++)
            run(1'($urandom_range(0, 1)), 2'($urandom_range(0, 3)), 5'($urandom_range(0, 7)),
                5'($urandom_range(0, 7)), 5'($urandom_range(0, 7)), $urandom);
        // reset during WB abandons the write
        @(negedge clk);
        cmd_valid = 1'b1; cmd_load = 1'b1; cmd_rd = 5'd5; cmd_imm = ~ref_rf[5];
        @(posedge clk); #1;
        cmd_valid = 1'b0;
        chk("wb_we3_high", 32'(dp_we3), 32'd1);
        rst_n = 1'b0;
        #1;
        chk("rst_we3_drop", 32'({dp_we3, rsp_valid, busy, cmd_ready}), 32'b0001);
        chk("rst_count_clear", 32'(op_count), 32'd0);
        ref_cnt = '0;
        @(negedge clk) rst_n = 1'b1;
        @(posedge clk); #1;
        chk("rst_write_abandoned", rf[5], ref_rf[5]);
        chk("rst_idle", 32'(cmd_ready), 32'd1);
        run(1'b0, 2'd1, 5'd8, 5'd5, 5'd1, 32'h0);
        // counter wrap
        @(negedge clk);
        force dut.op_count = 16'hFFFF;
        #1 release dut.op_count;
        ref_cnt = 16'hFFFF;
        run(1'b1, 2'd0, 5'd9, 5'd0, 5'd0, 32'hCAFE_0001);
        chk("wrap_zero", 32'(op_count), 32'd0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
